debounce3: RTL and testbench
============================

// Module: debounce3
// PURPOSE
// - Three-channel push-button/switch conditioner feeding the 3-input OR gate stage (x0, x1, x2).
// - Per channel: 2-flop synchronizer, then a debounce FSM with a counter.
// - Outputs a clean level per channel; optionally one-cycle rise/fall pulses.
// - Sits between the board pins and the combinational gate under test.
// PARAMETERS
// - DB_COUNT  12000  consecutive stable cycles before an output changes (1 ms @ 12 MHz); must be >= 2
// - CNT_W     14     debounce counter width; DB_COUNT < 2**CNT_W is required
// PORTS
// - clk     in   1  system clock; all logic on rising edge
// - rst     in   1  reset, synchronous, active-high
// - btn_in  in   3  raw asynchronous inputs; bit i = channel i
// - x_out   out  3  debounced levels; bit0->x0, bit1->x1, bit2->x2 of the OR stage
// - rise    out  3  one-cycle pulse when x_out[i] goes 0->1 (see CONFIGURATION)
// - fall    out  3  one-cycle pulse when x_out[i] goes 1->0 (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): sync flops, x_out, rise, fall, counters = 0; every FSM -> STABLE.
//   - Takes effect on that edge; any in-progress count is discarded.
// - Synchronizer: s1[i] <= btn_in[i]; s2[i] <= s1[i]; the FSM sees only s2.
// - Per-channel FSM (channels fully independent; simultaneous activity on all three is legal):
//   - STABLE: s2==x_out -> stay, cnt=0.
//     - s2!=x_out -> COUNTING, cnt<=1.
//   - COUNTING, s2==x_out (bounce back): -> STABLE, cnt<=0, x_out unchanged, no pulse.
//   - COUNTING, s2!=x_out, cnt==DB_COUNT-1: x_out<=s2, -> STABLE, cnt<=0, pulse asserted.
//   - COUNTING, s2!=x_out, cnt<DB_COUNT-1: cnt<=cnt+1.
// - Net rule: x_out[i] changes only after s2[i] has differed from it for DB_COUNT consecutive edges.
// - Latency: btn_in change before edge k (1st edge), held steady ->
//   - x_out updates on edge k+DB_COUNT+1 (the DB_COUNT+2-th edge).
// - Any bounce inside the window restarts the count from zero.
// - rise[i]/fall[i] are registered: high exactly the one cycle after x_out[i] changes, 0 otherwise.
//   - Never both high on the same channel.
// - Counter never exceeds DB_COUNT-1; no wrap-around possible.
// - Input pulses shorter than DB_COUNT cycles (after sync) never reach x_out.
// - x_out is glitch-free (register output); safe to drive the combinational OR stage directly.
// CONFIGURATION
// - Macro DEBOUNCE3_EDGE_EN:
//   - defined: rise/fall generated as described in BEHAVIOUR.
//   - undefined: rise and fall ports remain, constantly tied to 3'b000; no edge registers built.
// - x_out behaviour is identical in both builds.
// TESTING (bench uses DB_COUNT=4, CNT_W=3)
// - rst=1 two cycles, btn_in=3'b111 during reset -> x_out=000, rise=fall=000 while rst high.
// - btn_in[0] 0->1 before edge k, held -> x_out=001 after edge k+5; rise=001 for exactly that cycle (EDGE_EN).
// - btn_in[1] toggles 1,0,1,0 each cycle then holds 1 -> x_out[1] stays 0 until 4 stable post-sync edges, then 1.
// - btn_in 000->111 simultaneously, held -> x_out=111 on same edge, rise=111 one cycle.
//   - Then 111->000 -> fall=111 one cycle.
// - btn_in[2]=1 for 3 cycles then 0 -> x_out[2] never rises, rise[2] never pulses.
// - Mid-count reset: btn_in[0]=1, assert rst after 2 cycles of counting -> x_out=000.
//   - Count restarts from 0 after release; x_out[0]=1 DB_COUNT+2 edges after rst deasserts.
// - Build without DEBOUNCE3_EDGE_EN, repeat scenario 2 -> identical x_out timing, rise=fall=000 always.

Source files
------------

// File: rtl/debounce3.sv
// Three-channel button conditioner: 2-flop sync + per-channel debounce FSM.
// Define DEBOUNCE3_EDGE_EN to build the registered rise/fall pulse outputs.
module debounce3 #(
  parameter int unsigned DB_COUNT = 12000,
  parameter int unsigned CNT_W    = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_in,
  output logic [2:0] x_out,
  output logic [2:0] rise,
  output logic [2:0] fall
);

  typedef enum logic {STABLE, COUNTING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  state_t           state     [3];
  state_t           state_nxt [3];
  logic [CNT_W-1:0] cnt       [3];
  logic [CNT_W-1:0] cnt_nxt   [3];
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       upd;
  logic [2:0]       x_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      x_out <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1    <= btn_in;
      s2    <= s1;
      x_out <= x_nxt;
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        STABLE: begin
          if (s2[i] != x_out[i]) begin
            state_nxt[i] = COUNTING;
            cnt_nxt[i]   = CNT_W'(1);
          end else begin
            cnt_nxt[i] = '0;
          end
        end
        COUNTING: begin
          // Bounce-back and window completion both return to STABLE with a cleared count
          if ((s2[i] == x_out[i]) || (cnt[i] == CNT_LAST)) begin
            state_nxt[i] = STABLE;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        default: begin
          state_nxt[i] = STABLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      upd[i] = (state[i] == COUNTING) && (s2[i] != x_out[i]) && (cnt[i] == CNT_LAST);
    end
    x_nxt = x_out ^ upd;
  end

`ifdef DEBOUNCE3_EDGE_EN
  // Pulses load on the same edge as x_out, so they cover the cycle right after the change
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= upd & s2;
      fall <= upd & ~s2;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_debounce3.sv
// Directed bench for debounce3 with DB_COUNT=4, CNT_W=3; expectations follow
// the edge-pulse build when DEBOUNCE3_EDGE_EN is defined, else pulses stay 0.
module tb_debounce3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_in;
  logic [2:0] x_out;
  logic [2:0] rise;
  logic [2:0] fall;

  int vectors = 0;
  int miscompares = 0;

`ifdef DEBOUNCE3_EDGE_EN
  logic [2:0] edge_mask = 3'b111;
`else
  logic [2:0] edge_mask = 3'b000;
`endif

  debounce3 #(.DB_COUNT(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .x_out  (x_out),
    .rise   (rise),
    .fall   (fall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ex, input logic [2:0] er,
                         input logic [2:0] ef);
    chk({tag, ".x"},    x_out, ex);
    chk({tag, ".rise"}, rise,  er & edge_mask);
    chk({tag, ".fall"}, fall,  ef & edge_mask);
  endtask

  initial begin
    // Reset with all inputs high
    rst = 1'b1;
    btn_in = 3'b111;
    tick();
    chk_all("rst1", 3'b000, 3'b000, 3'b000);
    tick();
    chk_all("rst2", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    btn_in = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("idle", 3'b000, 3'b000, 3'b000);
    end

    // Channel 0 press: output on 6th edge, rise that cycle only
    btn_in = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("c0_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("c0_rise", 3'b001, 3'b001, 3'b000);
    tick();
    chk_all("c0_after", 3'b001, 3'b000, 3'b000);

    // Channel 1 bounce 1,0,1,0 then hold 1: changes on 10th edge
    btn_in = 3'b011; tick(); chk_all("c1_b1", 3'b001, 3'b000, 3'b000);
    btn_in = 3'b001; tick(); chk_all("c1_b2", 3'b001, 3'b000, 3'b000);
    btn_in = 3'b011; tick(); chk_all("c1_b3", 3'b001, 3'b000, 3'b000);
    btn_in = 3'b001; tick(); chk_all("c1_b4", 3'b001, 3'b000, 3'b000);
    btn_in = 3'b011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("c1_hold", 3'b001, 3'b000, 3'b000);
    end
    tick();
    chk_all("c1_rise", 3'b011, 3'b010, 3'b000);
    tick();
    chk_all("c1_after", 3'b011, 3'b000, 3'b000);

    // Release both to 000
    btn_in = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("rel_wait", 3'b011, 3'b000, 3'b000);
    end
    tick();
    chk_all("rel_fall", 3'b000, 3'b000, 3'b011);
    tick();
    chk_all("rel_after", 3'b000, 3'b000, 3'b000);

    // All three together: 000->111 then 111->000
    btn_in = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("all_up_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("all_rise", 3'b111, 3'b111, 3'b000);
    tick();
    chk_all("all_rise_after", 3'b111, 3'b000, 3'b000);
    btn_in = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("all_dn_wait", 3'b111, 3'b000, 3'b000);
    end
    tick();
    chk_all("all_fall", 3'b000, 3'b000, 3'b111);
    tick();
    chk_all("all_fall_after", 3'b000, 3'b000, 3'b000);

    // Channel 2 short pulse (3 cycles) is filtered out
    btn_in = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("c2_pulse", 3'b000, 3'b000, 3'b000);
    end
    btn_in = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("c2_filtered", 3'b000, 3'b000, 3'b000);
    end

    // Mid-count reset discards progress; full window needed afterwards
    btn_in = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("mid_count", 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b1;
    tick();
    chk_all("mid_rst", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("post_rst_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    chk_all("post_rst_rise", 3'b001, 3'b001, 3'b000);
    tick();
    chk_all("post_rst_after", 3'b001, 3'b000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
